// File: rtl/bip_control.sv
// Control unit for a small accumulator processor: two-cycle FETCH/EXEC sequencer
// that decodes one instruction word into datapath strobes per EXEC cycle.
module bip_control #(
  parameter int AB = 11,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_bip,
  input  logic [IW-1:0] instr,
  output logic [AB-1:0] address_bus,
  output logic          WrPC,
  output logic [AB-1:0] Operand,
  output logic [1:0]    SelA,
  output logic          SelB,
  output logic          WrAcc,
  output logic          WrRam,
  output logic          RdRam,
  output logic          Op,
  output logic          halted,
  output logic          illegal,
  output logic [15:0]   instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t        state;
  logic [AB-1:0] pc;
  logic [AB-1:0] pc_inc;
  logic [4:0]    opcode;
  logic          hlt_p1;

  assign opcode = instr[IW-1:IW-5];
  assign pc_inc = pc + {{(AB-1){1'b0}}, 1'b1};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Strobes are decoded on the FETCH->EXEC edge so they are registered and
  // line up with the EXEC cycle; instr is valid during FETCH for address_bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      address_bus <= '0;
      Operand     <= '0;
      hlt_p1      <= 1'b0;
      WrPC        <= 1'b0;
      SelA        <= 2'b00;
      SelB        <= 1'b0;
      WrAcc       <= 1'b0;
      WrRam       <= 1'b0;
      RdRam       <= 1'b0;
      Op          <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      WrPC  <= 1'b0;
      SelA  <= 2'b00;
      SelB  <= 1'b0;
      WrAcc <= 1'b0;
      WrRam <= 1'b0;
      RdRam <= 1'b0;
      Op    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_bip) begin
            state       <= FETCH;
            address_bus <= pc;
            WrPC        <= 1'b1;
          end
        end
        FETCH: begin
          state   <= EXEC;
          Operand <= instr[AB-1:0];
          hlt_p1  <= (opcode == 5'b00000);
          case (opcode)
            5'b00000: ;
            5'b00001: WrRam <= 1'b1;
            5'b00010: begin
              RdRam <= 1'b1;
              SelA  <= 2'b00;
              WrAcc <= 1'b1;
            end
            5'b00011: begin
              SelA  <= 2'b01;
              WrAcc <= 1'b1;
            end
            // opcode[1] distinguishes SUB/SUBI from ADD/ADDI
            5'b00100, 5'b00110: begin
              RdRam <= 1'b1;
              SelB  <= 1'b1;
              SelA  <= 2'b10;
              WrAcc <= 1'b1;
              Op    <= opcode[1];
            end
            5'b00101, 5'b00111: begin
              SelB  <= 1'b0;
              SelA  <= 2'b10;
              WrAcc <= 1'b1;
              Op    <= opcode[1];
            end
            default: illegal <= 1'b1;
          endcase
        end
        EXEC: begin
          if (hlt_p1) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state       <= FETCH;
            pc          <= pc_inc;
            address_bus <= pc_inc;
            WrPC        <= 1'b1;
            instr_count <= sat_inc(instr_count);
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: a reference decoder walks each program and
// queues expected fetch addresses and EXEC strobe vectors for the monitor.
module tb_bip_control;
  localparam int AB = 11;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_bip = 1'b0;
  logic [IW-1:0] instr;
  logic [AB-1:0] address_bus;
  logic          WrPC;
  logic [AB-1:0] Operand;
  logic [1:0]    SelA;
  logic          SelB, WrAcc, WrRam, RdRam, Op, halted, illegal;
  logic [15:0]   instr_count;

  logic [IW-1:0] mem [0:(1<<AB)-1];

  int checks = 0;
  int errors = 0;

  logic [AB-1:0] addr_q [$];
  logic [AB+7:0] exec_q [$];
  logic          mon_en = 1'b0;
  logic          exec_next = 1'b0;
  int            exp_cnt;
  logic          exp_ill;

  bip_control #(.AB(AB), .IW(IW)) dut (
    .clk(clk), .reset(reset), .start_bip(start_bip), .instr(instr),
    .address_bus(address_bus), .WrPC(WrPC), .Operand(Operand),
    .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc), .WrRam(WrRam), .RdRam(RdRam),
    .Op(Op), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  assign instr = mem[address_bus];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [4:0] op, input logic [AB-1:0] opd);
    logic [IW-1:0] w;
    w = '0;
    w[IW-1:IW-5] = op;
    w[AB-1:0] = opd;
    return w;
  endfunction

  function automatic logic [AB+7:0] model_exec(input logic [IW-1:0] w, input logic ill_in);
    logic [4:0] op;
    logic [1:0] sa;
    logic sb, wa, wr, rr, o, il;
    op = w[IW-1:IW-5];
    sa = 2'b00; sb = 1'b0; wa = 1'b0; wr = 1'b0; rr = 1'b0; o = 1'b0; il = ill_in;
    case (op)
      5'd0: ;
      5'd1: wr = 1'b1;
      5'd2: begin rr = 1'b1; wa = 1'b1; end
      5'd3: begin sa = 2'b01; wa = 1'b1; end
      5'd4: begin rr = 1'b1; sb = 1'b1; sa = 2'b10; wa = 1'b1; end
      5'd5: begin sa = 2'b10; wa = 1'b1; end
      5'd6: begin rr = 1'b1; sb = 1'b1; sa = 2'b10; wa = 1'b1; o = 1'b1; end
      5'd7: begin sa = 2'b10; wa = 1'b1; o = 1'b1; end
      default: il = 1'b1;
    endcase
    return {w[AB-1:0], sa, sb, wa, wr, rr, o, il};
  endfunction

  task automatic build_sb();
    logic [AB-1:0] pc;
    logic [IW-1:0] w;
    logic ill;
    int cnt;
    pc = '0; ill = 1'b0; cnt = 0;
    for (int n = 0; n < 4096; n++) begin
      w = mem[pc];
      addr_q.push_back(pc);
      exec_q.push_back(model_exec(w, ill));
      if (w[IW-1:IW-5] > 5'd7) ill = 1'b1;
      if (w[IW-1:IW-5] == 5'd0) break;
      cnt++;
      pc = pc + 1'b1;
    end
    exp_cnt = cnt;
    exp_ill = ill;
  endtask

  always @(negedge clk) begin
    if (reset || !mon_en) begin
      exec_next <= 1'b0;
    end else if (WrPC) begin
      if (addr_q.size() == 0) check("addr_q_underflow", 32'd1, 32'd0);
      else check("fetch_addr", 32'(address_bus), 32'(addr_q.pop_front()));
      exec_next <= 1'b1;
    end else if (exec_next) begin
      if (exec_q.size() == 0) check("exec_q_underflow", 32'd1, 32'd0);
      else check("exec_strobes", 32'({Operand, SelA, SelB, WrAcc, WrRam, RdRam, Op, illegal}),
                 32'(exec_q.pop_front()));
      exec_next <= 1'b0;
    end else begin
      check("idle_strobes", 32'({SelA, SelB, WrAcc, WrRam, RdRam, Op}), 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({address_bus, WrPC, Operand, SelA, SelB, WrAcc, WrRam, RdRam,
                               Op, halted, illegal}), 32'd0);
    check({tag, "_count"}, 32'(instr_count), 32'd0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    start_bip = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    addr_q.delete();
    exec_q.delete();
    for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    if (!halted) check("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_checks(input string name);
    repeat (4) @(negedge clk);
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_count"}, 32'(instr_count), 32'(exp_cnt));
    check({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
    check({name, "_sb_left"}, 32'(addr_q.size() + exec_q.size()), 32'd0);
    start_bip = 1'b0;
  endtask

  task automatic run_prog(input bit hold_start, input string name);
    build_sb();
    mon_en = 1'b1;
    @(negedge clk);
    start_bip = 1'b1;
    if (!hold_start) begin
      @(negedge clk);
      start_bip = 1'b0;
    end
    wait_halt(200);
    finish_checks(name);
  endtask

  initial begin
    bit found;
    bit seen;

    // LDI 5, ADDI 3, HLT
    do_reset();
    mem[0] = mk(5'd3, 11'd5);
    mem[1] = mk(5'd5, 11'd3);
    mem[2] = mk(5'd0, 11'd0);
    run_prog(1'b0, "ldi_addi");

    // LD 0x010, SUB 0x011, STO 0x012, HLT
    do_reset();
    mem[0] = mk(5'd2, 11'h010);
    mem[1] = mk(5'd6, 11'h011);
    mem[2] = mk(5'd1, 11'h012);
    mem[3] = mk(5'd0, 11'h000);
    run_prog(1'b0, "ld_sub_sto");

    // undefined opcode then HLT, plus SUBI to cover the remaining decode
    do_reset();
    mem[0] = mk(5'b11111, 11'h055);
    mem[1] = mk(5'd7, 11'h002);
    mem[2] = mk(5'd0, 11'h7AA);
    run_prog(1'b0, "illegal");

    // 2048 NOPs walk pc through 0x7FF and wrap; address 0 becomes HLT after its first run
    do_reset();
    for (int i = 0; i < (1 << AB); i++) mem[i] = mk(5'b01000, AB'(i));
    for (int i = 0; i < (1 << AB); i++) begin
      addr_q.push_back(AB'(i));
      exec_q.push_back(model_exec(mem[i], 1'b1));
    end
    addr_q.push_back('0);
    exec_q.push_back(model_exec(mk(5'd0, 11'h000), 1'b1));
    exp_cnt = 1 << AB;
    exp_ill = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    start_bip = 1'b1;
    @(negedge clk);
    start_bip = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (address_bus == 11'd1) found = 1'b1;
    end
    check("wrap_reach_addr1", 32'(found), 32'd1);
    mem[0] = mk(5'd0, 11'h000);
    wait_halt(6000);
    finish_checks("wrap");
    check("wrap_addr_hold", 32'(address_bus), 32'd0);

    // asynchronous reset in the middle of ADDI's EXEC with start held high
    do_reset();
    mem[0] = mk(5'd3, 11'd5);
    mem[1] = mk(5'd5, 11'd3);
    mem[2] = mk(5'd0, 11'd0);
    @(negedge clk);
    start_bip = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (WrPC && address_bus == 11'd1) found = 1'b1;
    end
    check("areset_reach_fetch1", 32'(found), 32'd1);
    @(posedge clk);
    #2;
    check("areset_wracc_before", 32'(WrAcc), 32'd1);
    reset = 1'b1;
    #1;
    check("areset_wracc_after", 32'(WrAcc), 32'd0);
    check_all_zero("areset");
    repeat (3) @(negedge clk);
    start_bip = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (WrPC || address_bus != '0) seen = 1'b1;
    end
    check("areset_stays_idle", 32'(seen), 32'd0);
    run_prog(1'b1, "restart_held");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
